// File: rtl/wb_mailbox.sv
// -----------------------------------------------------------------------------
// wb_mailbox -- Wishbone B4 pipelined responder bridging a bus initiator and
// local logic through two small FIFOs.
//
//   TX FIFO : bus writes to DATA  -> local consumer (tx_valid/tx_ready/tx_data)
//   RX FIFO : local producer      -> bus reads of DATA (rx_valid/rx_ready/rx_data)
//
// Register map (wb_adr_i):
//   0 DATA   write pushes TX, read pops RX (returns 0 when RX is empty)
//   1 STATUS read-only; writes are acked and ignored
//            bit0                         RX non-empty
//            bit1                         TX full
//            [2+DEPTH_LOG2:2]             RX count
//            [2*DEPTH_LOG2+3:3+DEPTH_LOG2] TX count
//            WIDTH must be at least 2*DEPTH_LOG2+4 to hold the status word.
//
// Ports:
//   wb_clk_i    clock
//   wb_rst_i    asynchronous active-low reset
//   wb_cyc_i    bus cycle active
//   wb_stb_i    request strobe
//   wb_we_i     1 = write, 0 = read
//   wb_adr_i    0 = DATA, 1 = STATUS
//   wb_dat_i    write data
//   wb_dat_o    read data, registered, held between reads
//   wb_stall_o  request not accepted this cycle (write DATA with TX full)
//   wb_ack_o    one-cycle ack, one cycle after acceptance
//   int_rx      RX FIFO non-empty (registered)
//   tx_valid    TX head valid
//   tx_ready    consumer takes TX head
//   tx_data     TX head
//   rx_valid    producer offers a word
//   rx_ready    RX FIFO not full
//   rx_data     producer word
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// wb_mailbox_fifo -- synchronous FIFO with first-word-fall-through head.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset (pointers only)
//   push_i        write data_i (ignored when full)
//   data_i        write data
//   pop_i         drop head (ignored when empty)
//   head_o        current head word (undefined when empty)
//   count_o       occupancy, 0..2^DEPTH_LOG2
//   empty_o       no words stored
//   full_o        2^DEPTH_LOG2 words stored
// -----------------------------------------------------------------------------
module wb_mailbox_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                push_en;
  logic                pop_en;

  // Pointers carry one extra bit: equal low bits with differing MSBs means
  // the writer has lapped the reader exactly once, i.e. full.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  assign head_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: a word is only visible once the write pointer
  // has moved past it.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= data_i;
    end
  end

endmodule

module wb_mailbox #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic             wb_adr_i,
  input  logic [WIDTH-1:0] wb_dat_i,
  output logic [WIDTH-1:0] wb_dat_o,
  output logic             wb_stall_o,
  output logic             wb_ack_o,
  output logic             int_rx,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [WIDTH-1:0] tx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [WIDTH-1:0] rx_data
);

  localparam logic [DEPTH_LOG2:0] CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // FIFO instances
  // ---------------------------------------------------------------------------
  logic                tx_push, tx_pop, tx_empty, tx_full;
  logic [DEPTH_LOG2:0] tx_count;
  logic                rx_push, rx_pop, rx_empty, rx_full;
  logic [DEPTH_LOG2:0] rx_count;
  logic [WIDTH-1:0]    rx_head;

  wb_mailbox_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_i),
    .push_i  (tx_push),
    .data_i  (wb_dat_i),
    .pop_i   (tx_pop),
    .head_o  (tx_data),
    .count_o (tx_count),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  wb_mailbox_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_i),
    .push_i  (rx_push),
    .data_i  (rx_data),
    .pop_i   (rx_pop),
    .head_o  (rx_head),
    .count_o (rx_count),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  // ---------------------------------------------------------------------------
  // Bus request decode
  // ---------------------------------------------------------------------------
  logic req;
  logic accept;
  logic rd_accept;

  assign req = wb_cyc_i & wb_stb_i;

  // Only a DATA write can stall. tx_full comes from registered pointers, so
  // a consumer pop in the same cycle does not un-stall the write until the
  // following cycle.
  assign wb_stall_o = req & wb_we_i & ~wb_adr_i & tx_full;
  assign accept     = req & ~wb_stall_o;
  assign rd_accept  = accept & ~wb_we_i;

  assign tx_push = accept & wb_we_i & ~wb_adr_i;
  // A DATA read of an empty RX is acked with 0; the FIFO ignores the pop.
  assign rx_pop  = rd_accept & ~wb_adr_i;

  // ---------------------------------------------------------------------------
  // Local-side handshakes
  // ---------------------------------------------------------------------------
  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;

  // ---------------------------------------------------------------------------
  // Read data mux
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] status_word;
  logic [WIDTH-1:0] rd_data;

  always_comb begin
    status_word                          = '0;
    status_word[0]                       = ~rx_empty;
    status_word[1]                       = tx_full;
    status_word[2 +: DEPTH_LOG2+1]       = rx_count;
    status_word[3+DEPTH_LOG2 +: DEPTH_LOG2+1] = tx_count;
  end

  always_comb begin
    rd_data = '0;
    if (wb_adr_i) begin
      rd_data = status_word;
    end else if (!rx_empty) begin
      rd_data = rx_head;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             int_rx_q, int_rx_d;
  logic             rx_pop_eff;

  assign rx_pop_eff = rx_pop & ~rx_empty;

  always_comb begin
    ack_d = accept;
    dat_d = dat_q;
    if (rd_accept) begin
      dat_d = rd_data;
    end
    // Next-cycle occupancy is non-zero when something is pushed, when more
    // than one word is stored, or when the single stored word stays.
    int_rx_d = rx_push | (rx_count > CNT_ONE) |
               ((rx_count == CNT_ONE) & ~rx_pop_eff);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      int_rx_q <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      int_rx_q <= int_rx_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign int_rx   = int_rx_q;

endmodule
